// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a decoded request (one-hot class, ALU code,
// register indices, immediate) into a 32-bit instruction word plus its memory address.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  op_class,
    input  logic [3:0]  alu_ctrl,
    input  logic [2:0]  func3_in,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        addr_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_addr;
    logic        r_err;
    logic [31:0] r_next_addr;

    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_instr;
    logic [2:0]  w_alu_f3;
    logic        w_alu_b30;
    logic        w_alu_ok;
    logic        w_alu_shift;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Upstream: in_ready is high when the single output register is empty or being drained.
    // Downstream: out_valid stays high with stable data until out_ready is seen.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err       = r_err;

    always_comb begin
        w_alu_f3    = 3'b000;
        w_alu_b30   = 1'b0;
        w_alu_ok    = 1'b1;
        w_alu_shift = 1'b0;
        case (alu_ctrl)
            4'b0000: w_alu_f3 = 3'b000;
            4'b0001: begin w_alu_f3 = 3'b001; w_alu_shift = 1'b1; end
            4'b0010: w_alu_f3 = 3'b010;
            4'b0011: w_alu_f3 = 3'b011;
            4'b0100: w_alu_f3 = 3'b100;
            4'b0101: begin w_alu_f3 = 3'b101; w_alu_shift = 1'b1; end
            4'b0110: begin w_alu_f3 = 3'b101; w_alu_b30 = 1'b1; w_alu_shift = 1'b1; end
            4'b0111: w_alu_f3 = 3'b110;
            4'b1000: w_alu_f3 = 3'b111;
            4'b1001: begin w_alu_f3 = 3'b000; w_alu_b30 = 1'b1; end
            default: w_alu_ok = 1'b0;
        endcase
    end

    // Class priority below is irrelevant for legal requests, which are strictly one-hot.
    always_comb begin
        w_instr = 32'h0;
        w_legal = $onehot(op_class);
        if (op_class[0]) begin
            w_instr = {1'b0, w_alu_b30, 5'b0, rs2, rs1, w_alu_f3, rd, OP_R};
            if (!w_alu_ok) w_legal = 1'b0;
        end else if (op_class[1]) begin
            if (w_alu_shift)
                w_instr = {1'b0, w_alu_b30, 5'b0, imm[4:0], rs1, w_alu_f3, rd, OP_I};
            else
                w_instr = {imm[11:0], rs1, w_alu_f3, rd, OP_I};
            if (!w_alu_ok || alu_ctrl == 4'b1001) w_legal = 1'b0;
        end else if (op_class[2]) begin
            w_instr = {imm[11:5], rs2, rs1, func3_in, imm[4:0], OP_STORE};
            if (func3_in > 3'b010) w_legal = 1'b0;
        end else if (op_class[3]) begin
            w_instr = {imm[11:0], rs1, func3_in, rd, OP_LOAD};
            if (func3_in == 3'b011 || func3_in == 3'b110 || func3_in == 3'b111) w_legal = 1'b0;
        end else if (op_class[4]) begin
            w_instr = {imm[12], imm[10:5], rs2, rs1, func3_in, imm[4:1], imm[11], OP_BRANCH};
            if (func3_in == 3'b010 || func3_in == 3'b011) w_legal = 1'b0;
        end else if (op_class[5]) begin
            w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        end else if (op_class[6]) begin
            w_instr = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        end else if (op_class[7]) begin
            w_instr = {imm[31:12], rd, OP_LUI};
        end else if (op_class[8]) begin
            w_instr = {imm[31:12], rd, OP_AUIPC};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0;
            r_out_addr  <= 32'h0;
            r_err       <= 1'b0;
            r_next_addr <= BASE_ADDR;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= r_next_addr;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A word accepted together with addr_clr still takes the pre-clear address.
            if (addr_clr)
                r_next_addr <= BASE_ADDR;
            else if (w_accept && w_legal)
                r_next_addr <= (r_next_addr == LAST_ADDR) ? BASE_ADDR : r_next_addr + 32'd4;
        end
    end

endmodule
